// File: rtl/rv_lsu_mem_if.sv
// Load/store unit bridging the Q103H memory stage to a variable-latency data memory.
// Handles lane alignment, byte enables, load extension, pipeline stall and timeout abort.
module rv_lsu_mem_if #(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned TIMEOUT_CYC = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid_Q103H,
  input  logic                  rd_en_Q103H,
  input  logic                  wr_en_Q103H,
  input  logic [1:0]            size_Q103H,
  input  logic                  sign_ext_Q103H,
  input  logic [ADDR_W-1:0]     addr_Q103H,
  input  logic [DATA_W-1:0]     wr_data_Q103H,
  output logic                  stall_Q103H,
  output logic [DATA_W-1:0]     rd_data_Q103H,
  output logic                  rd_data_vld_Q103H,
  output logic                  err_misaligned_Q103H,
  output logic                  err_timeout_Q103H,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic [ADDR_W-1:0]     mem_req_addr,
  output logic                  mem_req_wr_en,
  output logic                  mem_req_rd_en,
  output logic [DATA_W/8-1:0]   mem_req_byte_en,
  output logic [DATA_W-1:0]     mem_req_wr_data,
  input  logic                  mem_rsp_valid,
  input  logic [DATA_W-1:0]     mem_rsp_data
);

  localparam int unsigned BE_W    = DATA_W / 8;
  localparam int unsigned OFF_W   = $clog2(BE_W);
  localparam int unsigned IDX_W   = $clog2(DATA_W);
  localparam int unsigned CNT_W   = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam int unsigned TO_LAST = (TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0;

  typedef enum logic [1:0] {IDLE, REQ, RSP, DONE} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [OFF_W-1:0]    off_q, off_d;
  logic [1:0]          size_q, size_d;
  logic                sign_q, sign_d;
  logic                rd_q, rd_d;
  logic                wr_q, wr_d;
  logic [BE_W-1:0]     be_q, be_d;
  logic [DATA_W-1:0]   wdat_q, wdat_d;
  logic [DATA_W-1:0]   rdat_q, rdat_d;
  logic                to_q, to_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  logic                access, mis, start, expired;
  logic [OFF_W-1:0]    off_i;
  logic [BE_W-1:0]     be_base;
  logic [DATA_W-1:0]   rsp_sh, rd_ext;
  logic [IDX_W-1:0]    msb;

  assign off_i   = addr_Q103H[OFF_W-1:0];
  assign access  = valid_Q103H & (rd_en_Q103H | wr_en_Q103H);
  assign start   = (state_q == IDLE) & access & ~mis;
  assign expired = (TIMEOUT_CYC != 0) && (cnt_q == CNT_W'(TO_LAST));

  always_comb begin
    mis     = 1'b0;
    be_base = '0;
    case (size_Q103H)
      2'd0: be_base = BE_W'(1);
      2'd1: begin
        be_base = BE_W'(3);
        mis     = addr_Q103H[0];
      end
      2'd2: begin
        be_base = BE_W'(15);
        mis     = |addr_Q103H[1:0];
      end
      default: begin
        be_base = '1;
        mis     = (DATA_W == 32) || (|addr_Q103H[2:0]);
      end
    endcase
  end

  // Shift the selected lanes down to bit 0, then replicate the access-size MSB upward.
  always_comb begin
    rsp_sh = mem_rsp_data >> {off_q, 3'b000};
    case (size_q)
      2'd0:    msb = IDX_W'(7);
      2'd1:    msb = IDX_W'(15);
      2'd2:    msb = IDX_W'(31);
      default: msb = IDX_W'(DATA_W - 1);
    endcase
    rd_ext = '0;
    for (int unsigned i = 0; i < DATA_W; i++)
      rd_ext[i] = (i <= 32'(msb)) ? rsp_sh[i] : (sign_q & rsp_sh[msb]);
  end

  always_comb begin
    state_d              = state_q;
    addr_d               = addr_q;
    off_d                = off_q;
    size_d               = size_q;
    sign_d               = sign_q;
    rd_d                 = rd_q;
    wr_d                 = wr_q;
    be_d                 = be_q;
    wdat_d               = wdat_q;
    rdat_d               = rdat_q;
    to_d                 = to_q;
    cnt_d                = cnt_q;
    err_misaligned_Q103H = 1'b0;
    case (state_q)
      IDLE: begin
        if (access && mis) begin
          err_misaligned_Q103H = 1'b1;
        end else if (start) begin
          state_d = REQ;
          addr_d  = {addr_Q103H[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
          off_d   = off_i;
          size_d  = size_Q103H;
          sign_d  = sign_ext_Q103H;
          wr_d    = wr_en_Q103H;
          rd_d    = rd_en_Q103H & ~wr_en_Q103H;
          be_d    = be_base << off_i;
          wdat_d  = wr_data_Q103H << {off_i, 3'b000};
          rdat_d  = '0;
          to_d    = 1'b0;
          cnt_d   = '0;
        end
      end
      REQ: begin
        cnt_d = cnt_q + 1'b1;
        if (mem_req_ready) begin
          state_d = wr_q ? DONE : RSP;
        end else if (expired) begin
          state_d = DONE;
          to_d    = 1'b1;
        end
      end
      RSP: begin
        cnt_d = cnt_q + 1'b1;
        if (mem_rsp_valid) begin
          state_d = DONE;
          rdat_d  = rd_ext;
        end else if (expired) begin
          state_d = DONE;
          to_d    = 1'b1;
          rdat_d  = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      off_q   <= '0;
      size_q  <= '0;
      sign_q  <= 1'b0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      be_q    <= '0;
      wdat_q  <= '0;
      rdat_q  <= '0;
      to_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      off_q   <= off_d;
      size_q  <= size_d;
      sign_q  <= sign_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      be_q    <= be_d;
      wdat_q  <= wdat_d;
      rdat_q  <= rdat_d;
      to_q    <= to_d;
      cnt_q   <= cnt_d;
    end
  end

  assign stall_Q103H       = start | (state_q == REQ) | (state_q == RSP);
  assign rd_data_Q103H     = rdat_q;
  assign rd_data_vld_Q103H = (state_q == DONE) & rd_q & ~to_q;
  assign err_timeout_Q103H = (state_q == DONE) & to_q;
  assign mem_req_valid     = (state_q == REQ);
  assign mem_req_addr      = addr_q;
  assign mem_req_wr_en     = (state_q == REQ) & wr_q;
  assign mem_req_rd_en     = (state_q == REQ) & rd_q;
  assign mem_req_byte_en   = be_q;
  assign mem_req_wr_data   = wdat_q;

endmodule
